// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state type and default sizing for the Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_MASTERS    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin find-first starting just after last_idx
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_idx_i,
    output logic [IW-1:0] win_idx_o,
    output logic          win_vld_o
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester after last_idx is left standing.
    always_comb begin
        win_idx_o = '0;
        win_vld_o = 1'b0;
        cand      = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_idx_i) + k) % N);
            if (req_i[cand]) begin
                win_idx_o = cand;
                win_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin Wishbone bus arbiter; WB_ARB_TIMEOUT_EN adds an ack watchdog
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IW             = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] cyc_i,
    input  logic                   ack_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [IW-1:0]          gnt_idx_o,
    output logic                   gnt_vld_o,
    output logic [NUM_MASTERS-1:0] err_o
);

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [IW-1:0]          gnt_idx_q;
    logic                   gnt_vld_q;
    logic [NUM_MASTERS-1:0] err_q;
    logic [IW-1:0]          last_idx_q;

    logic [IW-1:0]          win_idx;
    logic                   win_vld;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] cnt_q;
    logic          term_hit;
    assign term_hit = !ack_i && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ack_i ^ TIMEOUT_CYCLES[0];
`endif

    rr_priority_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .req_i      (cyc_i),
        .last_idx_i (last_idx_q),
        .win_idx_o  (win_idx),
        .win_vld_o  (win_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            err_q      <= '0;
            last_idx_q <= IW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q    <= BUSY;
                        gnt_q      <= NUM_MASTERS'(1) << win_idx;
                        gnt_idx_q  <= win_idx;
                        gnt_vld_q  <= 1'b1;
                        last_idx_q <= win_idx;
`ifdef WB_ARB_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A master dropping cyc releases the bus even if its watchdog expires the same cycle.
                    if (!cyc_i[gnt_idx_q]) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        gnt_idx_q <= '0;
                        gnt_vld_q <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (term_hit) begin
                        state_q   <= ERR;
                        err_q     <= gnt_q;
                        gnt_q     <= '0;
                        gnt_idx_q <= '0;
                        gnt_vld_q <= 1'b0;
                    end else if (ack_i) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign gnt_vld_o = gnt_vld_q;
    assign err_o     = err_q;

endmodule
